// File: rtl/cell_mem_ctrl_pkg.sv
// Shared types and constants for the cell position RAM access controller.
package cell_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_REQ,
    CNT_WAIT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned RD_LATENCY     = 2;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/cell_mem_ctrl_fifo.sv
// Output skid FIFO for the particle stream; level feeds the read credit check.
module cell_mem_ctrl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (push) store[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Head is forced to zero when empty so stale storage never reaches the outputs.
  assign empty = (level == '0);
  assign rdata = empty ? '0 : store[rptr];

endmodule

// File: rtl/cell_mem_ctrl.sv
// Single-port cell RAM controller: count read, credited particle stream, write arbitration.
// Optional contention counter enabled by CELL_MEM_CTRL_PERF_EN.
module cell_mem_ctrl
  import cell_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] cell_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [31:0]           contention_cnt
);

  localparam int unsigned FW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int unsigned WW = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [WW-1:0]           wait_cnt;
  logic                    last_popped;
  logic                    prio_wr;
  logic [RD_LATENCY-1:0]   pipe_v;
  logic [ADDR_WIDTH-1:0]   pipe_pid [RD_LATENCY];

  logic                    rd_req, rd_grant, wr_grant, contend, credit_ok;
  logic                    push, pop, fifo_empty;
  logic [FW-1:0]           push_word, head;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [ADDR_WIDTH-1:0]   q_count;

  // Credit covers reads still in the RAM pipe so the FIFO can never overflow.
  assign credit_ok = (32'(fifo_level) + 32'($countones(pipe_v))) < FIFO_DEPTH;
  assign rd_req    = (state == CNT_REQ) || ((state == STREAM) && credit_ok);
  assign contend   = rd_req && wr_valid;
  assign wr_grant  = wr_valid && (!rd_req || prio_wr);
  assign rd_grant  = rd_req && !(wr_valid && prio_wr);
  assign wr_ready  = wr_grant;

  assign q_count = (mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) ? MAX_COUNT : mem_q[ADDR_WIDTH-1:0];

  always_comb begin
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    if (rd_grant) begin
      mem_rden    = 1'b1;
      mem_address = (state == STREAM) ? next_addr : '0;
    end else if (wr_grant) begin
      mem_wren    = 1'b1;
      mem_address = wr_addr;
      mem_data    = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_wr <= 1'b0;
    end else if (contend) begin
      prio_wr <= rd_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_pid[i] <= '0;
    end else begin
      pipe_v[0]   <= rd_grant && (state == STREAM);
      pipe_pid[0] <= next_addr;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_pid[i] <= pipe_pid[i-1];
      end
    end
  end

  assign push      = pipe_v[RD_LATENCY-1];
  assign push_word = {(pipe_pid[RD_LATENCY-1] == cell_count), pipe_pid[RD_LATENCY-1], mem_q};
  assign pop       = out_valid && out_ready;

  cell_mem_ctrl_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign {out_last, out_pid, out_data} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_busy     <= 1'b0;
      rd_done     <= 1'b0;
      cell_count  <= '0;
      next_addr   <= '0;
      wait_cnt    <= '0;
      last_popped <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (pop && out_last) last_popped <= 1'b1;
      case (state)
        IDLE: begin
          if (rd_start) begin
            state       <= CNT_REQ;
            rd_busy     <= 1'b1;
            last_popped <= 1'b0;
          end
        end
        CNT_REQ: begin
          if (rd_grant) begin
            state    <= CNT_WAIT;
            wait_cnt <= '0;
          end
        end
        CNT_WAIT: begin
          if (wait_cnt == WW'(RD_LATENCY - 1)) begin
            cell_count <= q_count;
            if (q_count == '0) begin
              state   <= DONE;
              rd_done <= 1'b1;
              rd_busy <= 1'b0;
            end else begin
              state     <= STREAM;
              next_addr <= ADDR_WIDTH'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        STREAM: begin
          if (rd_grant) begin
            if (next_addr == cell_count) state <= DRAIN;
            else next_addr <= next_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if ((pipe_v == '0) && (last_popped || (pop && out_last))) begin
            state   <= DONE;
            rd_done <= 1'b1;
            rd_busy <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CELL_MEM_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if ((state == IDLE) && rd_start) begin
      perf_q <= '0;
    end else if (contend && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign contention_cnt = perf_q;
`else
  assign contention_cnt = '0;
`endif

endmodule

// File: doc/cell_mem_ctrl.md
Name: cell_mem_ctrl

Overview:
Access controller for one single-port cell position RAM. The RAM has a 2-cycle read latency, and address 0 holds the particle count.
- Force-evaluation side: streams a cell's particles out with a valid/ready handshake, after first reading the count.
- Motion-update side: shares the same RAM port for position/count write-back.
- Sits between the position cache and each cell RAM instance.

Parameters:
DATA_WIDTH, 96, packed {posz, posy, posx} word width
ADDR_WIDTH, 8, RAM address width
PARTICLE_NUM, 220, RAM depth; maximum count = PARTICLE_NUM-1
FIFO_DEPTH, 4, output skid FIFO depth (power of 2, >= 4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_start  in  1  pulse: begin streaming this cell
rd_busy  out  1  read sequence in progress
rd_done  out  1  1-cycle pulse: sequence complete
cell_count  out  ADDR_WIDTH  count latched from address 0
out_valid  out  1  stream data valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  particle position
out_pid  out  ADDR_WIDTH  particle address (1..count)
out_last  out  1  marks final particle
wr_valid  in  1  write request
wr_ready  out  1  write granted this cycle
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
mem_address  out  ADDR_WIDTH  to RAM
mem_data  out  DATA_WIDTH  to RAM
mem_rden  out  1  to RAM
mem_wren  out  1  to RAM
mem_q  in  DATA_WIDTH  from RAM
contention_cnt  out  32  arbitration-loss counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, in-flight pipe cleared, arbitration priority = read. Reset mid-sequence abandons the sequence: no rd_done, FIFO flushed.
- RAM port driven combinationally from the arbiter each cycle:
  - Read: mem_rden=1, mem_wren=0.
  - Write: mem_wren=1, mem_rden=0, mem_address=wr_addr, mem_data=wr_data.
  - Idle: both 0.
- Arbitration:
  - A write is granted (wr_ready=1, combinational) when no read wants the port, or when both contend and priority = write.
  - The winner of a contention cycle takes lowest priority next.
  - Writes are accepted in any FSM state, including IDLE.
- FSM states:
  - IDLE: rd_start -> CNT_REQ, rd_busy=1. rd_start while busy is ignored.
  - CNT_REQ: request read of address 0; on grant -> CNT_WAIT.
  - CNT_WAIT: 2 cycles, then latch mem_q[ADDR_WIDTH-1:0] into cell_count, clamped to PARTICLE_NUM-1. Count 0 -> DONE; otherwise -> STREAM with next address = 1.
  - STREAM: request a read of the next address when (fifo_level + inflight) < FIFO_DEPTH. On grant, increment the address. After address = count is granted -> DRAIN.
  - DRAIN: wait until inflight = 0 and the last particle has been popped -> DONE.
  - DONE: rd_done=1 for one cycle, rd_busy=0 -> IDLE.
- Read pipeline:
  - A 2-stage valid/pid shift register tracks in-flight reads.
  - Data is pushed into the FIFO on the cycle mem_q is valid (issue+2).
  - The FIFO never overflows because of the credit check above.
- Output:
  - out_valid = FIFO not empty; FIFO head drives out_data, out_pid and out_last (out_last = pid == count).
  - Pop on out_valid & out_ready. out_data holds stable while out_valid & !out_ready.
- Latency, no write contention, out_ready=1 (rd_start sampled in cycle 0):
  - cycle 1: mem_rden, address 0
  - cycle 3: count latched
  - cycle 4: read of address 1 issued
  - cycle 7: first out_valid
  - afterwards: one particle per cycle
- Count 0: rd_done in cycle 4, no out_valid.
- Read and write on the same address in the same cycle cannot occur (single port; the arbiter grants one). A write to address 0 during STREAM does not alter the latched cell_count.

Optional Feature:
- Macro: CELL_MEM_CTRL_PERF_EN.
- Defined: contention_cnt increments, saturating at 2^32-1, on every cycle in which a read request and wr_valid are both present. Cleared on reset and on rd_start accepted in IDLE.
- Undefined: contention_cnt tied to 0; no counter logic.

Decomposition:
- Package cell_mem_ctrl_pkg: FSM state enum (IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE), RD_LATENCY=2 constant, FIFO_DEPTH default.
- One sub-module: cell_mem_ctrl_fifo, a synchronous FIFO carrying {out_last, pid, data} that exposes level for the credit check.

Test Plan:
- Count=3, out_ready=1, wr_valid=0 -> out_valid cycles 7,8,9; pids 1,2,3; out_last on pid 3; rd_done cycle 10.
- Count=0 -> no out_valid; rd_done cycle 4; cell_count=0.
- Count=10, out_ready held low after the first accept -> FIFO level reaches 4, mem_rden stops, out_data stable; release -> all 10 particles delivered in order, none lost or duplicated.
- Count=5 with wr_valid held high throughout -> grants alternate read/write each contention cycle; all 5 particles delivered. With CELL_MEM_CTRL_PERF_EN, contention_cnt equals the number of contention cycles.
- rd_n deasserted while streaming particle 3 of 8 -> all outputs 0 next cycle, no rd_done; new rd_start after release streams from pid 1.
- Address 0 word = PARTICLE_NUM+5 -> cell_count=219; rd_start pulsed while busy is ignored (single rd_done).
